// File: rtl/rx_pingpong_seq_if.sv
// Control/status bundle for the ping-pong comparator bank sequencer.
// Latency: n/a (pure signal grouping, no logic).
// Backpressure: none; run/duration inputs are levels, status outputs are registered levels/pulses.
interface rx_pingpong_seq_if #(
    parameter int STEP_W = 8,
    parameter int HOLD_W = 16,
    parameter int CNT_W  = 16
);
    // Run request and phase durations.
    logic              en;
    logic [STEP_W-1:0] step_cycles;
    logic [HOLD_W-1:0] hold_cycles;

    // Bank controls, mux select and status.
    logic              a_pc;
    logic              a_en;
    logic              b_pc;
    logic              b_en;
    logic              sel_a;
    logic              busy;
    logic              swap;
    logic [CNT_W-1:0]  swap_cnt;

    // Controller side: drives run/duration, observes bank controls.
    modport master (
        output en, step_cycles, hold_cycles,
        input  a_pc, a_en, b_pc, b_en, sel_a, busy, swap, swap_cnt
    );

    // Sequencer side.
    modport slave (
        input  en, step_cycles, hold_cycles,
        output a_pc, a_en, b_pc, b_en, sel_a, busy, swap, swap_cnt
    );
endinterface

// File: rtl/rx_pingpong_seq.sv
// Ping-pong comparator bank sequencer: make-before-break handover between banks A and B, one control change per step.
// Latency: outputs registered; a state's output values appear on the same edge that enters the state.
// Backpressure: none; en is only looked at in IDLE and at HOLD expiry, so a started handover always completes.
module rx_pingpong_seq #(
    parameter int STEP_W = 8,
    parameter int HOLD_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rstb,
    rx_pingpong_seq_if.slave bus
);

    localparam int DUR_W = (STEP_W > HOLD_W) ? STEP_W : HOLD_W;

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_PC_OFF,
        S_A_EN_ON,
        S_SEL_A,
        S_B_EN_OFF,
        S_B_PC_ON,
        S_HOLD_A,
        S_B_PC_OFF,
        S_B_EN_ON,
        S_SEL_B,
        S_A_EN_OFF,
        S_A_PC_ON,
        S_HOLD_B,
        S_PARK_A_EN_OFF,
        S_PARK_A_PC_ON
    } state_t;

    state_t           state_q, state_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic [DUR_W-1:0] step_ld, hold_ld;
    logic             expired;
    logic             entering;
    logic             entering_hold;

    logic             a_pc_q, a_pc_d;
    logic             a_en_q, a_en_d;
    logic             b_pc_q, b_pc_d;
    logic             b_en_q, b_en_d;
    logic             sel_a_q, sel_a_d;
    logic             busy_q, busy_d;
    logic             swap_q, swap_d;
    logic [CNT_W-1:0] swap_cnt_q, swap_cnt_d;

    // Reload values (duration minus one); a zero duration behaves as one cycle.
    always_comb begin
        step_ld = '0;
        hold_ld = '0;
        if (bus.step_cycles != '0) begin
            step_ld = DUR_W'(bus.step_cycles) - DUR_W'(1);
        end
        if (bus.hold_cycles != '0) begin
            hold_ld = DUR_W'(bus.hold_cycles) - DUR_W'(1);
        end
    end

    // Next-state: walk the ring when the current state's down-counter has run out.
    always_comb begin
        state_d = state_q;
        expired = (cnt_q == '0);
        case (state_q)
            S_IDLE:          if (bus.en)  state_d = S_A_PC_OFF;
            S_A_PC_OFF:      if (expired) state_d = S_A_EN_ON;
            S_A_EN_ON:       if (expired) state_d = S_SEL_A;
            S_SEL_A:         if (expired) state_d = S_B_EN_OFF;
            S_B_EN_OFF:      if (expired) state_d = S_B_PC_ON;
            S_B_PC_ON:       if (expired) state_d = S_HOLD_A;
            S_HOLD_A:        if (expired) state_d = bus.en ? S_B_PC_OFF : S_PARK_A_EN_OFF;
            S_B_PC_OFF:      if (expired) state_d = S_B_EN_ON;
            S_B_EN_ON:       if (expired) state_d = S_SEL_B;
            S_SEL_B:         if (expired) state_d = S_A_EN_OFF;
            S_A_EN_OFF:      if (expired) state_d = S_A_PC_ON;
            S_A_PC_ON:       if (expired) state_d = S_HOLD_B;
            S_HOLD_B:        if (expired) state_d = bus.en ? S_A_PC_OFF : S_IDLE;
            S_PARK_A_EN_OFF: if (expired) state_d = S_PARK_A_PC_ON;
            S_PARK_A_PC_ON:  if (expired) state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Duration counter: durations are captured only on state entry, so mid-state
    // changes on step_cycles/hold_cycles wait for the next state.
    always_comb begin
        entering      = (state_d != state_q);
        entering_hold = entering && ((state_d == S_HOLD_A) || (state_d == S_HOLD_B));
        cnt_d         = cnt_q;
        if (state_d == S_IDLE) begin
            cnt_d = '0;
        end else if (entering) begin
            cnt_d = entering_hold ? hold_ld : step_ld;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DUR_W'(1);
        end
    end

    // Output next values: each state touches one control, the rest hold. Re-applying
    // the same change while the state is held is harmless, so no entry qualifier is needed.
    always_comb begin
        a_pc_d     = a_pc_q;
        a_en_d     = a_en_q;
        b_pc_d     = b_pc_q;
        b_en_d     = b_en_q;
        sel_a_d    = sel_a_q;
        busy_d     = (state_d != S_IDLE);
        swap_d     = entering_hold;
        swap_cnt_d = entering_hold ? (swap_cnt_q + CNT_W'(1)) : swap_cnt_q;
        case (state_d)
            S_IDLE: begin
                a_pc_d  = 1'b1;
                a_en_d  = 1'b0;
                b_pc_d  = 1'b1;
                b_en_d  = 1'b0;
                sel_a_d = 1'b1;
            end
            S_A_PC_OFF:      a_pc_d  = 1'b0;
            S_A_EN_ON:       a_en_d  = 1'b1;
            S_SEL_A:         sel_a_d = 1'b1;
            S_B_EN_OFF:      b_en_d  = 1'b0;
            S_B_PC_ON:       b_pc_d  = 1'b1;
            S_B_PC_OFF:      b_pc_d  = 1'b0;
            S_B_EN_ON:       b_en_d  = 1'b1;
            S_SEL_B:         sel_a_d = 1'b0;
            S_A_EN_OFF:      a_en_d  = 1'b0;
            S_A_PC_ON:       a_pc_d  = 1'b1;
            S_PARK_A_EN_OFF: a_en_d  = 1'b0;
            S_PARK_A_PC_ON:  a_pc_d  = 1'b1;
            default: ;
        endcase
    end

    // Counter and output registers; swap_cnt is the only output cleared by reset alone.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            cnt_q      <= '0;
            a_pc_q     <= 1'b1;
            a_en_q     <= 1'b0;
            b_pc_q     <= 1'b1;
            b_en_q     <= 1'b0;
            sel_a_q    <= 1'b1;
            busy_q     <= 1'b0;
            swap_q     <= 1'b0;
            swap_cnt_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            a_pc_q     <= a_pc_d;
            a_en_q     <= a_en_d;
            b_pc_q     <= b_pc_d;
            b_en_q     <= b_en_d;
            sel_a_q    <= sel_a_d;
            busy_q     <= busy_d;
            swap_q     <= swap_d;
            swap_cnt_q <= swap_cnt_d;
        end
    end

    assign bus.a_pc     = a_pc_q;
    assign bus.a_en     = a_en_q;
    assign bus.b_pc     = b_pc_q;
    assign bus.b_en     = b_en_q;
    assign bus.sel_a    = sel_a_q;
    assign bus.busy     = busy_q;
    assign bus.swap     = swap_q;
    assign bus.swap_cnt = swap_cnt_q;

    // A bank must never be precharged while enabled, and the held bank must be the live one.
    a_excl_chk: assert property (@(posedge clk) disable iff (!rstb) !(a_en_q && a_pc_q));
    b_excl_chk: assert property (@(posedge clk) disable iff (!rstb) !(b_en_q && b_pc_q));
    hold_a_chk: assert property (@(posedge clk) disable iff (!rstb)
                    (state_q == S_HOLD_A) |-> (sel_a_q && a_en_q && !a_pc_q));
    hold_b_chk: assert property (@(posedge clk) disable iff (!rstb)
                    (state_q == S_HOLD_B) |-> (!sel_a_q && b_en_q && !b_pc_q));

endmodule

// File: tb/tb_rx_pingpong_seq.sv
// Self-checking bench for rx_pingpong_seq: expected events are queued per cycle and compared as the DUT reaches them.
// Latency: cycle offsets are counted from the edge that samples the stimulus (offset 0 = that edge).
// Backpressure: none; every scenario loop is bounded by a fixed cycle count.
module tb_rx_pingpong_seq;

    logic clk;
    logic rstb;

    rx_pingpong_seq_if #(.STEP_W(8), .HOLD_W(16), .CNT_W(16)) ifc ();
    rx_pingpong_seq_if #(.STEP_W(8), .HOLD_W(16), .CNT_W(2))  ifc2 ();

    assign ifc2.en          = ifc.en;
    assign ifc2.step_cycles = ifc.step_cycles;
    assign ifc2.hold_cycles = ifc.hold_cycles;

    rx_pingpong_seq #(.STEP_W(8), .HOLD_W(16), .CNT_W(16)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (ifc)
    );

    rx_pingpong_seq #(.STEP_W(8), .HOLD_W(16), .CNT_W(2)) dut_w2 (
        .clk  (clk),
        .rstb (rstb),
        .bus  (ifc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   passed  = 0;
    int   exp_cnt = 0;

    function automatic logic [31:0] obs(input int s);
        case (s)
            0:       obs = 32'(ifc.a_pc);
            1:       obs = 32'(ifc.a_en);
            2:       obs = 32'(ifc.b_pc);
            3:       obs = 32'(ifc.b_en);
            4:       obs = 32'(ifc.sel_a);
            5:       obs = 32'(ifc.busy);
            6:       obs = 32'(ifc.swap);
            7:       obs = 32'(ifc.swap_cnt);
            8:       obs = 32'(ifc2.swap_cnt);
            9:       obs = 32'(ifc2.swap);
            default: obs = 'x;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Insert keeping the queue ordered by cycle (stable for equal cycles).
    task automatic push(input int cyc, input int sig, input int val, input string name);
        exp_t e;
        int   i;
        e.cyc  = cyc;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= cyc) i++;
        sb.insert(i, e);
    endtask

    task automatic push_idle(input int cyc, input int cnt);
        push(cyc, 0, 1, "a_pc idle");
        push(cyc, 1, 0, "a_en idle");
        push(cyc, 2, 1, "b_pc idle");
        push(cyc, 3, 0, "b_en idle");
        push(cyc, 4, 1, "sel_a idle");
        push(cyc, 5, 0, "busy idle");
        push(cyc, 6, 0, "swap idle");
        push(cyc, 7, cnt, "swap_cnt idle");
    endtask

    task automatic test_reset();
        exp_t e;
        rstb = 1'b0;
        ifc.en = 1'b0;
        ifc.step_cycles = 8'd2;
        ifc.hold_cycles = 16'd5;
        tick();
        tick();
        push_idle(0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (obs(e.sig) !== 32'(e.val))
                $display("FAIL reset %s: got %0h want %0h", e.name, obs(e.sig), e.val);
            else passed++;
        end
        rstb = 1'b1;
        exp_cnt = 0;
    endtask

    // step=2, hold=5 full ring: timeline from edge k.
    task automatic test_sequence();
        exp_t e;
        ifc.en = 1'b1;
        tick();
        push(0, 0, 0, "a_pc off");
        push(0, 5, 1, "busy on");
        push(1, 1, 0, "a_en still off");
        push(2, 1, 1, "a_en on");
        push(4, 4, 1, "sel_a A");
        push(8, 2, 1, "b_pc on");
        push(9, 6, 0, "swap before hold_a");
        push(10, 6, 1, "swap hold_a");
        push(10, 7, exp_cnt + 1, "swap_cnt 1st");
        push(11, 6, 0, "swap one cycle");
        push(15, 2, 0, "b_pc off");
        push(17, 3, 1, "b_en on");
        push(19, 4, 0, "sel_a B");
        push(25, 6, 1, "swap hold_b");
        push(25, 7, exp_cnt + 2, "swap_cnt 2nd");
        push(30, 0, 0, "a_pc off loop");
        push(40, 6, 1, "swap hold_a 2");
        push(40, 7, exp_cnt + 3, "swap_cnt 3rd");
        for (int c = 0; c <= 40; c++) begin
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sig) !== 32'(e.val))
                    $display("FAIL seq %s @%0d: got %0h want %0h", e.name, c, obs(e.sig), e.val);
                else passed++;
            end
            if (c < 40) tick();
        end
        exp_cnt += 3;
    endtask

    // Continues from the start of HOLD_A left by test_sequence: drop en, expect park.
    task automatic test_park();
        exp_t e;
        ifc.en = 1'b0;
        push(0, 1, 1, "a_en in hold");
        push(1, 6, 0, "swap low");
        push(4, 1, 1, "a_en before expiry");
        push(4, 5, 1, "busy in hold");
        push(5, 1, 0, "park a_en off");
        push(5, 0, 0, "park a_pc still off");
        push(6, 1, 0, "park a_en stays");
        push(7, 0, 1, "park a_pc on");
        push(8, 5, 1, "busy in park");
        push(9, 5, 0, "busy idle after park");
        push(9, 2, 1, "b_pc after park");
        push(9, 4, 1, "sel_a after park");
        push(9, 7, exp_cnt, "swap_cnt no extra");
        for (int c = 0; c <= 9; c++) begin
            checks++;
            if (ifc.b_en !== 1'b0)
                $display("FAIL park b_en @%0d: got %0h want 0", c, ifc.b_en);
            else passed++;
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sig) !== 32'(e.val))
                    $display("FAIL park %s @%0d: got %0h want %0h", e.name, c, obs(e.sig), e.val);
                else passed++;
            end
            if (c < 9) tick();
        end
    endtask

    // step=0, hold=0: every state one cycle, swap every 6 cycles, exclusivity every cycle.
    task automatic test_fast();
        exp_t e;
        ifc.step_cycles = 8'd0;
        ifc.hold_cycles = 16'd0;
        ifc.en = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            push(5 + 6 * i, 6, 1, "fast swap");
            push(5 + 6 * i, 7, exp_cnt + i + 1, "fast swap_cnt");
        end
        push(6, 6, 0, "fast swap low");
        push(12, 0, 0, "fast loop a_pc off");
        push(12, 6, 0, "fast swap low 2");
        push(35, 5, 1, "fast busy hold_b");
        push(36, 5, 0, "fast busy idle");
        for (int c = 0; c <= 36; c++) begin
            checks++;
            if ((ifc.a_en & ifc.a_pc) !== 1'b0 || (ifc.b_en & ifc.b_pc) !== 1'b0)
                $display("FAIL fast exclusivity @%0d: got a_en/a_pc/b_en/b_pc=%b%b%b%b want no en&pc",
                         c, ifc.a_en, ifc.a_pc, ifc.b_en, ifc.b_pc);
            else passed++;
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sig) !== 32'(e.val))
                    $display("FAIL fast %s @%0d: got %0h want %0h", e.name, c, obs(e.sig), e.val);
                else passed++;
            end
            if (c == 30) ifc.en = 1'b0;
            if (c < 36) tick();
        end
        exp_cnt += 6;
    endtask

    // en dropped in B_EN_ON: ring finishes through HOLD_B, one extra swap, then IDLE.
    task automatic test_drop_in_step();
        exp_t e;
        ifc.step_cycles = 8'd2;
        ifc.hold_cycles = 16'd5;
        ifc.en = 1'b1;
        tick();
        push(10, 7, exp_cnt + 1, "drop swap_cnt hold_a");
        push(17, 3, 1, "drop b_en on");
        push(19, 4, 0, "drop sel_a B");
        push(21, 1, 0, "drop a_en off");
        push(23, 0, 1, "drop a_pc on");
        push(25, 6, 1, "drop swap hold_b");
        push(25, 7, exp_cnt + 2, "drop swap_cnt hold_b");
        push(26, 6, 0, "drop swap low");
        push(29, 5, 1, "drop busy hold_b");
        push_idle(30, exp_cnt + 2);
        for (int c = 0; c <= 30; c++) begin
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sig) !== 32'(e.val))
                    $display("FAIL drop %s @%0d: got %0h want %0h", e.name, c, obs(e.sig), e.val);
                else passed++;
            end
            if (c == 17) ifc.en = 1'b0;
            if (c < 30) tick();
        end
        exp_cnt += 2;
    endtask

    // Durations are captured at state entry: a mid-state step change applies from the next state.
    task automatic test_mid_change();
        exp_t e;
        ifc.step_cycles = 8'd3;
        ifc.hold_cycles = 16'd5;
        ifc.en = 1'b1;
        tick();
        push(2, 1, 0, "midchg a_en still off");
        push(3, 1, 1, "midchg a_en on");
        push(6, 5, 1, "midchg busy");
        push(7, 6, 1, "midchg swap");
        push(7, 7, exp_cnt + 1, "midchg swap_cnt");
        push(11, 1, 1, "midchg a_en end hold");
        push(12, 1, 0, "midchg park a_en off");
        push(13, 0, 1, "midchg park a_pc on");
        push(13, 5, 1, "midchg busy park");
        push(14, 5, 0, "midchg busy idle");
        for (int c = 0; c <= 14; c++) begin
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sig) !== 32'(e.val))
                    $display("FAIL midchg %s @%0d: got %0h want %0h", e.name, c, obs(e.sig), e.val);
                else passed++;
            end
            if (c == 0) begin
                ifc.step_cycles = 8'd1;
                ifc.en = 1'b0;
            end
            if (c < 14) tick();
        end
        exp_cnt += 1;
    endtask

    // Reset asserted in SEL_B, then restart from A_PC_OFF with en=1.
    task automatic test_reset_mid();
        exp_t e;
        ifc.step_cycles = 8'd2;
        ifc.hold_cycles = 16'd5;
        ifc.en = 1'b1;
        tick();
        push(19, 4, 0, "rstmid sel_a B");
        push(19, 3, 1, "rstmid b_en on");
        push_idle(20, 0);
        push(21, 0, 0, "rstmid restart a_pc off");
        push(21, 5, 1, "rstmid restart busy");
        push(21, 7, 0, "rstmid cnt after restart");
        push(23, 1, 1, "rstmid a_en on");
        push(31, 6, 1, "rstmid swap");
        push(31, 7, 1, "rstmid swap_cnt");
        push(36, 1, 0, "rstmid park a_en off");
        push(38, 0, 1, "rstmid park a_pc on");
        push(40, 5, 0, "rstmid busy idle");
        for (int c = 0; c <= 40; c++) begin
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sig) !== 32'(e.val))
                    $display("FAIL rstmid %s @%0d: got %0h want %0h", e.name, c, obs(e.sig), e.val);
                else passed++;
            end
            if (c == 19) rstb = 1'b0;
            if (c == 20) rstb = 1'b1;
            if (c == 21) ifc.en = 1'b0;
            if (c < 40) tick();
        end
        exp_cnt = 1;
    endtask

    // 2-bit swap counter wraps: 1,2,3,0,1.
    task automatic test_wrap();
        exp_t e;
        rstb = 1'b0;
        ifc.en = 1'b0;
        tick();
        rstb = 1'b1;
        ifc.step_cycles = 8'd0;
        ifc.hold_cycles = 16'd0;
        ifc.en = 1'b1;
        tick();
        push(0, 8, 0, "wrap cnt start");
        for (int i = 0; i < 5; i++) begin
            push(5 + 6 * i, 9, 1, "wrap swap");
            push(5 + 6 * i, 8, (i + 1) % 4, "wrap swap_cnt");
        end
        push(29, 7, 5, "wide swap_cnt");
        push(32, 5, 0, "wrap busy idle");
        push(32, 8, 1, "wrap cnt held");
        for (int c = 0; c <= 32; c++) begin
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sig) !== 32'(e.val))
                    $display("FAIL wrap %s @%0d: got %0h want %0h", e.name, c, obs(e.sig), e.val);
                else passed++;
            end
            if (c == 29) ifc.en = 1'b0;
            if (c < 32) tick();
        end
    endtask

    initial begin
        rstb = 1'b0;
        ifc.en = 1'b0;
        ifc.step_cycles = 8'd2;
        ifc.hold_cycles = 16'd5;
        test_reset();
        test_sequence();
        test_park();
        test_fast();
        test_drop_in_step();
        test_mid_change();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/rx_pingpong_seq.md
RX_PINGPONG_SEQ -- requirements
Module: rx_pingpong_seq

Interface
REQ-001 Parameter STEP_W, default 8: width of the per-step settle counter.
REQ-002 Parameter HOLD_W, default 16: width of the hold counter.
REQ-003 Parameter CNT_W, default 16: width of the completed-swap counter.
REQ-004 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Port rstb  input  1: reset, synchronous and active-low.
REQ-006 Port en  input  1: run request; 1 = sequence continuously, 0 = park.
REQ-007 Port step_cycles  input  STEP_W: cycles per control step; 0 is treated as 1.
REQ-008 Port hold_cycles  input  HOLD_W: cycles per hold phase; 0 is treated as 1.
REQ-009 Port a_pc  output  1: comparator bank A precharge.
REQ-010 Port a_en  output  1: bank A enable.
REQ-011 Port b_pc  output  1: bank B precharge.
REQ-012 Port b_en  output  1: bank B enable.
REQ-013 Port sel_a  output  1: output mux select; 1 = bank A, 0 = bank B.
REQ-014 Port busy  output  1: high in every state except IDLE.
REQ-015 Port swap  output  1: one-cycle pulse on entry to HOLD_A or HOLD_B.
REQ-016 Port swap_cnt  output  CNT_W: count of swap pulses; wraps modulo 2^CNT_W.

Function
REQ-017 The block SHALL register all outputs; each state's output values SHALL become visible on the edge that enters the state.
REQ-018 The FSM SHALL have these states, in ring order: IDLE, A_PC_OFF, A_EN_ON, SEL_A, B_EN_OFF, B_PC_ON, HOLD_A, B_PC_OFF, B_EN_ON, SEL_B, A_EN_OFF, A_PC_ON, HOLD_B.
REQ-019 Each state SHALL change exactly one output relative to the previous state (a_pc=0, a_en=1, sel_a=1, b_en=0, b_pc=1, none, b_pc=0, b_en=1, sel_a=0, a_en=0, a_pc=1, none), all other outputs holding their values.
REQ-020 Each step state SHALL last max(step_cycles,1) cycles, and each HOLD state max(hold_cycles,1) cycles.
REQ-021 The duration input SHALL be sampled into the down-counter on state entry; changes mid-state SHALL take effect at the next state entry.
REQ-022 From IDLE, the FSM SHALL go to A_PC_OFF on the first edge sampling en=1.
REQ-023 From HOLD_B, on expiry, the FSM SHALL go to A_PC_OFF (loop) when en=1, else to IDLE.
REQ-024 From HOLD_A, on expiry, the FSM SHALL go to B_PC_OFF when en=1.
REQ-025 From HOLD_A, on expiry with en=0, the FSM SHALL go to PARK_A_EN_OFF (a_en=0, step duration), then PARK_A_PC_ON (a_pc=1, step duration), then IDLE.
REQ-026 The outputs in PARK_A_PC_ON SHALL equal the IDLE outputs.
REQ-027 en SHALL be examined only at HOLD expiry and in IDLE; deasserting en in a step state SHALL NOT abort the step sequence.
REQ-028 Invariant: a_en & a_pc = 0 and b_en & b_pc = 0 in every cycle.
REQ-029 Invariant: in HOLD_A, sel_a=1, a_en=1 and a_pc=0; in HOLD_B, sel_a=0, b_en=1 and b_pc=0.
REQ-030 swap_cnt SHALL increment on the same edge that asserts swap; swap and swap_cnt SHALL be unaffected by en.

Reset
REQ-031 With rstb=0 at an edge, the block SHALL enter IDLE from any state, including mid-sequence and mid-hold.
REQ-032 Reset values: a_pc=1, b_pc=1, a_en=0, b_en=0, sel_a=1, busy=0, swap=0, swap_cnt=0, counters=0.
REQ-033 IDLE outputs SHALL equal the reset values, except swap_cnt, which SHALL retain its value.

Verification
REQ-034 step=2, hold=5, en=1 sampled at edge k -> a_pc=0 at k, a_en=1 at k+2, b_pc=1 at k+8, swap at k+10; b_pc=0 at k+15, sel_a=0 at k+19, swap at k+25, swap at k+40; swap_cnt=3 after k+40.
REQ-035 step=0, hold=0 -> every state lasts 1 cycle; swap pulses every 6 cycles; the REQ-028 invariants hold every cycle.
REQ-036 en dropped during HOLD_A (step=2, hold=5) -> on expiry a_en=0, 2 cycles later a_pc=1, 2 cycles later busy=0; b_en stays 0 throughout.
REQ-037 en dropped during B_EN_ON -> sequence completes through HOLD_B, then IDLE; one extra swap pulse occurs.
REQ-038 rstb=0 during SEL_B -> next edge: all outputs at reset values, swap_cnt=0; with rstb=1 and en=1, the sequence restarts at A_PC_OFF.
REQ-039 CNT_W=2, run 5 swaps -> swap_cnt sequence 1,2,3,0,1.
